mem_stream_reader: RTL and testbench

Read-side controller for the single-port-write, asynchronous-read `memory` block. On a start command it walks a contiguous, wrapping address range, samples `memory.read_data`, and presents each word on a valid/ready output stream with a last-beat marker. It sits between the `memory` read port and any downstream consumer, such as a UART transmitter or checker, in the same clock domain as that consumer.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_stream_reader_if.sv | 35 +++
 rtl/memory.sv | 37 +++
 rtl/mem_stream_reader.sv | 138 +++++++++++++
 tb/tb_mem_stream_reader.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Types and helpers shared by the memory block and its read-side stream
// controller.
//   MEM_DATA_WIDTH / MEM_DATA_DEPTH : default geometry shared with `memory`
//   rd_state_t                      : stream reader state encoding
//   wrap_inc()                      : address increment modulo depth
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_DATA_WIDTH = 8;
  localparam int MEM_DATA_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,  // first fetch, output register known empty
    STREAM = 2'd2,
    FLUSH  = 2'd3   // last beat sits in the output register
  } rd_state_t;

  // Depth need not be a power of two, so wrap explicitly instead of
  // relying on address overflow.
  function automatic int wrap_inc(input int addr, input int depth);
    return (addr >= depth - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/mem_stream_reader_if.sv
// ---------------------------------------------------------------------------
// mem_stream_reader_if
// Valid/ready output stream of the memory stream reader.
//   out_valid : word present on out_data
//   out_ready : consumer accepts the word this cycle
//   out_data  : word read from memory
//   out_last  : final beat of the current stream
// master = producer (reader), slave = consumer.
// ---------------------------------------------------------------------------
interface mem_stream_reader_if
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
);

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/memory.sv
// ---------------------------------------------------------------------------
// memory
// Single-port-write, asynchronous-read word store.
//   write_clk  : write clock, rising edge
//   write_en   : write strobe
//   write_addr : write address
//   write_data : write word
//   read_addr  : read address
//   read_data  : combinational read of read_addr
// ---------------------------------------------------------------------------
module memory
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int DATA_DEPTH = MEM_DATA_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                  write_clk,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem_array [DATA_DEPTH];

  always_ff @(posedge write_clk) begin
    if (write_en) begin
      mem_array[write_addr] <= write_data;
    end
  end

  // Asynchronous read: the stream reader captures this at its fetch edge.
  assign read_data = mem_array[read_addr];

endmodule

// File: rtl/mem_stream_reader.sv
// ---------------------------------------------------------------------------
// mem_stream_reader
// Walks a contiguous, wrapping address range of `memory` on a start command
// and presents each word on a valid/ready stream with a last-beat marker.
//   read_clk, read_rst_n : clock (rising) and async active-low reset
//   start, start_addr, length : stream request, sampled only in IDLE
//   abort      : synchronous cancel, no done pulse
//   busy       : state is not IDLE
//   done       : one-cycle pulse after the last accept / zero-length start
//   read_addr  : to memory.read_addr
//   read_data  : from memory.read_data (combinational)
//   strm       : output stream (out_valid/out_ready/out_data/out_last)
// ---------------------------------------------------------------------------
module mem_stream_reader
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int DATA_DEPTH = MEM_DATA_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DATA_DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  read_clk,
  input  logic                  read_rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  mem_stream_reader_if.master   strm
);

  localparam logic [LEN_WIDTH-1:0] DEPTH_LEN = LEN_WIDTH'(DATA_DEPTH);
  localparam logic [LEN_WIDTH-1:0] ONE_LEN   = LEN_WIDTH'(1);

  rd_state_t             state_reg, state_next;
  logic [LEN_WIDTH-1:0]  remaining_reg;
  logic [ADDR_WIDTH-1:0] read_addr_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_valid_reg;
  logic                  out_last_reg;
  logic                  done_reg;

  logic                  fetch;
  logic                  accept;
  logic                  busy_int;
  logic [LEN_WIDTH-1:0]  len_sat;
  logic [ADDR_WIDTH-1:0] addr_inc;

  assign len_sat  = (length > DEPTH_LEN) ? DEPTH_LEN : length;
  assign addr_inc = ADDR_WIDTH'(wrap_inc(int'(read_addr_reg), DATA_DEPTH));

  // ---- state register ----
  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && (length != '0)) state_next = LOAD;
      LOAD:    state_next = (remaining_reg == ONE_LEN) ? FLUSH : STREAM;
      STREAM:  if (fetch && (remaining_reg == ONE_LEN)) state_next = FLUSH;
      FLUSH:   if (accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if ((state_reg != IDLE) && abort) begin
      state_next = IDLE;
    end
  end

  // ---- output / strobe decode ----
  // A fetch needs words left and a free (or draining) output register; in
  // LOAD the register is always empty, in FLUSH nothing remains, so one rule
  // covers every state.
  always_comb begin
    busy_int = (state_reg != IDLE);
    accept   = out_valid_reg && strm.out_ready;
    fetch    = busy_int && (remaining_reg != '0) &&
               (!out_valid_reg || strm.out_ready);
  end

  // ---- datapath registers ----
  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      remaining_reg <= '0;
      read_addr_reg <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (start) begin
          if (length == '0) begin
            done_reg <= 1'b1;
          end else begin
            read_addr_reg <= start_addr;
            remaining_reg <= len_sat;
          end
        end
      end else if (abort) begin
        // Abort outranks any fetch/accept in the same cycle.
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
        remaining_reg <= '0;
      end else if (fetch) begin
        out_data_reg  <= read_data;
        out_valid_reg <= 1'b1;
        out_last_reg  <= (remaining_reg == ONE_LEN);
        read_addr_reg <= addr_inc;
        remaining_reg <= remaining_reg - ONE_LEN;
      end else if (accept) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
        if (state_reg == FLUSH) begin
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy           = busy_int;
  assign done           = done_reg;
  assign read_addr      = read_addr_reg;
  assign strm.out_valid = out_valid_reg;
  assign strm.out_data  = out_data_reg;
  assign strm.out_last  = out_last_reg;

endmodule

// File: tb/tb_mem_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_mem_stream_reader
// Memory preloaded with mem[i] = i ^ 8'hA5, then directed and randomized
// streams compared against a queue of words computed from the reference
// memory image.
// ---------------------------------------------------------------------------
module tb_mem_stream_reader;
  import mem_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;

  logic          read_clk;
  logic          read_rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] length;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;

  mem_stream_reader_if #(.DATA_WIDTH(DW)) strm_if ();

  memory #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) u_mem (
    .write_clk  (read_clk),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr  (read_addr),
    .read_data  (read_data)
  );

  mem_stream_reader #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
    .read_clk   (read_clk),
    .read_rst_n (read_rst_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .strm       (strm_if.master)
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One stream transaction. stall_beat/stall_cycles hold ready low while
  // that beat is presented; rand_ready randomizes ready; busy_start_k pokes
  // a start at that cycle; abort_after aborts once that many beats are taken.
  task automatic run_stream(input int a, input int len, input int stall_beat,
                            input int stall_cycles, input bit rand_ready,
                            input int busy_start_k, input int abort_after);
    int            n, idx, stall_cnt, k;
    bit            finished, aborted, rdy, prev_hold, exp_done;
    logic [DW-1:0] held_d;
    logic          held_l;
    logic [DW-1:0] exp_q [$];

    n = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(a + i) % DEPTH]);

    @(negedge read_clk);
    start = 1'b1; start_addr = AW'(a); length = LW'(len);
    @(negedge read_clk);
    start = 1'b0;
    idx = 0; stall_cnt = 0; prev_hold = 1'b0; exp_done = 1'b0;
    finished = 1'b0; aborted = 1'b0; held_d = '0; held_l = 1'b0;

    for (k = 0; k < 1000; k++) begin
      if (k > 0) @(negedge read_clk);
      start = (k == busy_start_k);
      if (k == busy_start_k) begin
        start_addr = '0; length = LW'(1);
      end
      check("done", done, exp_done);
      check("busy", busy, !exp_done);
      if (exp_done) begin
        check("valid_after_done", strm_if.out_valid, 0);
        check("end_read_addr", read_addr, (a + n) % DEPTH);
        if (!rand_ready && stall_cycles == 0) check("latency", k, n + 1);
        finished = 1'b1;
        break;
      end
      if (k == 0) check("load_valid", strm_if.out_valid, 0);
      if (prev_hold) begin
        check("hold_data", strm_if.out_data, held_d);
        check("hold_last", strm_if.out_last, held_l);
      end
      if (abort_after >= 0 && idx == abort_after) begin
        abort = 1'b1; strm_if.out_ready = 1'b1;
        @(negedge read_clk);
        abort = 1'b0;
        check("abort_valid", strm_if.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge read_clk);
        check("abort_done2", done, 0);
        check("abort_valid2", strm_if.out_valid, 0);
        finished = 1'b1; aborted = 1'b1;
        break;
      end
      if (rand_ready) rdy = ($urandom_range(0, 3) != 0);
      else            rdy = !(idx == stall_beat && stall_cnt < stall_cycles);
      strm_if.out_ready = rdy;
      if (strm_if.out_valid && !rdy) stall_cnt++;
      prev_hold = strm_if.out_valid && !rdy;
      held_d    = strm_if.out_data;
      held_l    = strm_if.out_last;
      if (strm_if.out_valid && rdy) begin
        if (idx >= n) begin
          check("extra_beat", idx, n - 1);
        end else begin
          check("data", strm_if.out_data, exp_q[idx]);
          check("last", strm_if.out_last, (idx == n - 1));
          if (idx == n - 1) exp_done = 1'b1;
        end
        idx++;
      end
    end
    start = 1'b0;
    check("stream_finished", finished, 1);
    if (!aborted) check("beat_count", idx, n);
    strm_if.out_ready = 1'b1;
    $display("stream addr=%0d len=%0d beats=%0d aborted=%0d cycles=%0d",
             a, len, idx, aborted, k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    read_rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0;
    abort = 1'b0; write_en = 1'b0; write_addr = '0; write_data = '0;
    strm_if.out_ready = 1'b1;

    // Preload through the write port; the async-reset reader is held idle.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge read_clk);
      write_en = 1'b1; write_addr = AW'(i); write_data = DW'(i) ^ 8'hA5;
      ref_mem[i] = DW'(i) ^ 8'hA5;
    end
    @(negedge read_clk);
    write_en = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", strm_if.out_valid, 0);
    check("rst_last", strm_if.out_last, 0);
    check("rst_data", strm_if.out_data, 0);
    check("rst_addr", read_addr, 0);
    read_rst_n = 1'b1;

    run_stream(4, 3, -1, 0, 1'b0, -1, -1);
    run_stream(62, 4, -1, 0, 1'b0, -1, -1);
    run_stream(4, 3, 1, 3, 1'b0, -1, -1);

    // Zero length: done next cycle, no beats, stays idle.
    @(negedge read_clk);
    start = 1'b1; start_addr = AW'(9); length = '0;
    @(negedge read_clk);
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_valid", strm_if.out_valid, 0);
    check("zero_busy", busy, 0);
    @(negedge read_clk);
    check("zero_done_once", done, 0);
    check("zero_valid2", strm_if.out_valid, 0);
    $display("stream addr=9 len=0 beats=0");

    run_stream(10, 100, -1, 0, 1'b0, -1, -1);
    run_stream(30, 10, -1, 0, 1'b0, -1, 2);
    run_stream(12, 5, -1, 0, 1'b0, 2, -1);

    // Reset dropped between edges mid-stream.
    @(negedge read_clk);
    start = 1'b1; start_addr = AW'(20); length = LW'(10);
    @(negedge read_clk);
    start = 1'b0;
    repeat (3) @(posedge read_clk);
    #2 read_rst_n = 1'b0;
    #1;
    check("arst_valid", strm_if.out_valid, 0);
    check("arst_data", strm_if.out_data, 0);
    check("arst_last", strm_if.out_last, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", read_addr, 0);
    check("arst_done", done, 0);
    @(negedge read_clk);
    read_rst_n = 1'b1;
    @(negedge read_clk);
    check("arst_no_done", done, 0);
    $display("stream addr=20 len=10 reset mid-stream");
    run_stream(5, 6, -1, 0, 1'b0, -1, -1);

    for (int t = 0; t < 8; t++) begin
      run_stream(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 70)),
                 -1, 0, 1'b1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
